bcd_timer: RTL and testbench
============================

# bcd_timer

Parametrised BCD interval timer that generalises the fixed 60-second, two-digit countdown. It supports any digit count, any clock-to-tick ratio, a runtime-loadable preset, up or down counting, and pause/resume. An explicit state machine reports idle, running, paused and expired. It drives the per-digit seven-segment outputs through the shared seg7_decoder, and provides level and pulse time-out flags for the game-control FSM.

## Interface
- CLK_HZ, 50_000_000: input clock frequency.
- TICK_HZ, 1: count rate. DIV = CLK_HZ/TICK_HZ, which must be an integer ≥ 2.
- DIGITS, 2: number of BCD digits, 1..6.
- START_BCD, 'h60: preset loaded at reset, 4*DIGITS bits, every nibble ≤ 9.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- start  in  1  one-cycle pulse that begins a run from the preset.
- pause  in  1  level; while high in RUN the timer holds.
- load  in  1  one-cycle pulse that captures load_bcd into the preset and returns to IDLE.
- load_bcd  in  4*DIGITS  new preset, with digit 0 in the LSBs.
- up_mode  in  1  direction, sampled only on start: 1 = count 0 up to preset, 0 = count preset down to 0.
- bcd  out  4*DIGITS  current count.
- hex  out  7*DIGITS  seg7_decoder output per digit; digit i occupies [7i+6:7i].
- running  out  1  high in RUN.
- time_out  out  1  level, high in DONE.
- expired  out  1  one-cycle pulse on entry to DONE.
- tick  out  1  one-cycle pulse on each count-update edge.

## Operation
- Registers:
  - preset P, with reset value START_BCD.
  - count C, with reset value START_BCD.
  - mode bit M, with reset value 0 (down).
  - divider D, range 0..DIV-1, with reset value 0.
  - state, with reset value IDLE.
- States and transitions:
  - IDLE → RUN on start. On that edge C loads P if up_mode=0, or 0 if up_mode=1. M latches up_mode and D clears.
  - RUN → PAUSED when pause=1. D and C freeze.
  - PAUSED → RUN when pause=0. D resumes from its frozen value.
  - RUN → DONE on the tick edge that makes C equal the terminal value. The terminal value is 0 when M=0 and P when M=1. C holds at the terminal value.
  - DONE → RUN on start, which restarts exactly as from IDLE.
  - Any state → IDLE on load. P and C both take the clamped load_bcd, D clears, and M is unchanged.
- Input priority on one edge: load > start > pause.
  - start while in RUN or PAUSED restarts the run.
  - pause=1 together with start: start wins, and pause applies from the next edge.
- Terminal preset on start:
  - down mode with P=0, or up mode with P=0: the next state is DONE immediately, with expired pulsed and no tick.
- Load clamping: any load_bcd nibble > 9 is stored as 9.
- BCD arithmetic:
  - Down: digit 0 decrements. Each digit that is 0 becomes 9 and borrows from the next digit.
  - Up: digit 0 increments. Each digit that is 9 becomes 0 and carries to the next digit.
  - There is no wrap past the terminal value, because the state leaves RUN at the terminal value.
- Outputs:
  - running, time_out and expired are registered, with no combinational path from any input.
  - hex is the combinational decode of the registered bcd.

## Timing
- D increments every clk while in RUN. When D = DIV-1 in RUN, tick=1 that cycle, and on the same edge D→0 and C steps by one. The new C is visible the following cycle.
- First tick after start arrives DIV cycles after the start edge.
- expired is high for exactly the one cycle following the terminal tick edge, which is the first cycle time_out=1.
- The pause response takes effect on the first edge where pause is sampled high. Time accumulated in D is preserved across a pause.
- Reset mid-run: all outputs return to their reset values asynchronously:
  - bcd = START_BCD;
  - running, time_out, expired and tick all 0.
- load during DONE: time_out drops on the next cycle, and no expired pulse occurs.

## Test plan
- Default preset, CLK_HZ=10, TICK_HZ=1, DIGITS=2, down mode:
  - Stimulus: start.
  - Required: bcd reads 60, 59 … 01, 00, with ticks 10 cycles apart.
  - Required: expired is one cycle wide, exactly 600 cycles after start.
  - Required: time_out stays high and bcd holds 00 afterward.
- Up mode with load_bcd='h12:
  - Stimulus: load, then start with up_mode=1.
  - Required: bcd counts 00 → 09 → 10 → 11 → 12, then DONE.
  - Required: the 09→10 carry is correct.
- Pause:
  - Stimulus: assert pause for 37 cycles mid-run, 4 cycles after a tick.
  - Required: bcd is frozen during the pause.
  - Required: the next tick arrives 6 cycles after pause drops, i.e. the divider was preserved.
- Load clamping and priority:
  - Stimulus: load_bcd='hA5 pulsed together with start.
  - Required: P = 'h95 and the state is IDLE, so no run starts.
- Zero preset:
  - Stimulus: load 'h00, then start.
  - Required: DONE and expired on the next cycle, with no tick.
- Asynchronous reset:
  - Stimulus: drop reset mid-run, between clock edges.
  - Required: bcd returns to 'h60 and running=0 before the next clk edge.
  - Required: after reset releases, start behaves normally.

Source files
------------

// File: rtl/bcd_timer.sv
// rtl/bcd_timer.sv - parametrised BCD interval timer with seven-segment decode
//
// seg7_decoder : one BCD digit to active-high gfedcba segments (blank above 9)
//    digit  in  4  BCD digit
//    seg    out 7  segment pattern, bit 0 = a .. bit 6 = g
//
// bcd_timer : up/down BCD interval timer with pause, runtime preset and time-out flags
//    clk       in  1         system clock, rising edge
//    reset     in  1         asynchronous active-low reset
//    start     in  1         pulse: begin (or restart) a run from the preset
//    pause     in  1         level: hold the run while high
//    load      in  1         pulse: capture clamped load_bcd as preset, go idle
//    load_bcd  in  4*DIGITS  new preset, digit 0 in the LSBs
//    up_mode   in  1         direction, sampled on start (1 = count up to preset)
//    bcd       out 4*DIGITS  current count
//    hex       out 7*DIGITS  per-digit segment patterns, digit i at [7i+6:7i]
//    running   out 1         high while counting
//    time_out  out 1         high once the terminal value is reached
//    expired   out 1         one-cycle pulse on reaching the terminal value
//    tick      out 1         one-cycle pulse on each count-update edge

module seg7_decoder (
   input  logic [3:0] digit,
   output logic [6:0] seg
);
   always_comb begin
      seg = 7'h00;
      case (digit)
         4'd0: seg = 7'h3f;
         4'd1: seg = 7'h06;
         4'd2: seg = 7'h5b;
         4'd3: seg = 7'h4f;
         4'd4: seg = 7'h66;
         4'd5: seg = 7'h6d;
         4'd6: seg = 7'h7d;
         4'd7: seg = 7'h07;
         4'd8: seg = 7'h7f;
         4'd9: seg = 7'h6f;
         default: seg = 7'h00;
      endcase
   end
endmodule

module bcd_timer #(
   parameter int                CLK_HZ    = 50_000_000,
   parameter int                TICK_HZ   = 1,
   parameter int                DIGITS    = 2,
   parameter logic [4*DIGITS-1:0] START_BCD = 'h60
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                pause,
   input  logic                load,
   input  logic [4*DIGITS-1:0] load_bcd,
   input  logic                up_mode,
   output logic [4*DIGITS-1:0] bcd,
   output logic [7*DIGITS-1:0] hex,
   output logic                running,
   output logic                time_out,
   output logic                expired,
   output logic                tick
);
   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int W   = 4 * DIGITS;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    p_q, p_d, c_q, c_d;
   logic            m_q, m_d, exp_q, exp_d;
   logic [DW-1:0]   d_q, d_d;
   logic [W-1:0]    c_step, term, load_clamped;
   logic            div_wrap;

   // Ripple one BCD step through the digits; carry/borrow continues only
   // while digits wrap (9->0 going up, 0->9 going down).
   function automatic logic [W-1:0] bcd_step(input logic [W-1:0] v, input logic up);
      logic [W-1:0] r;
      logic         cy;
      logic [3:0]   nib;
      r  = v;
      cy = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         nib = v[4*i +: 4];
         if (cy) begin
            if (up) begin
               if (nib == 4'd9) nib = 4'd0;
               else begin nib = nib + 4'd1; cy = 1'b0; end
            end else begin
               if (nib == 4'd0) nib = 4'd9;
               else begin nib = nib - 4'd1; cy = 1'b0; end
            end
         end
         r[4*i +: 4] = nib;
      end
      return r;
   endfunction

   function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
      logic [W-1:0] r;
      r = v;
      for (int i = 0; i < DIGITS; i++)
         if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
      return r;
   endfunction

   assign c_step       = bcd_step(c_q, m_q);
   assign term         = m_q ? p_q : '0;
   assign load_clamped = bcd_clamp(load_bcd);
   assign div_wrap     = (d_q == DW'(DIV - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         p_q     <= START_BCD;
         c_q     <= START_BCD;
         m_q     <= 1'b0;
         d_q     <= '0;
         exp_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         c_q     <= c_d;
         m_q     <= m_d;
         d_q     <= d_d;
         exp_q   <= exp_d;
      end
   end

   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      c_d     = c_q;
      m_d     = m_q;
      d_d     = d_q;
      exp_d   = 1'b0;
      if (load) begin
         p_d     = load_clamped;
         c_d     = load_clamped;
         d_d     = '0;
         state_d = S_IDLE;
      end else if (start) begin
         m_d = up_mode;
         c_d = up_mode ? '0 : p_q;
         d_d = '0;
         // A zero preset is already terminal in either direction.
         if (p_q == '0) begin
            state_d = S_DONE;
            exp_d   = 1'b1;
         end else begin
            state_d = S_RUN;
         end
      end else begin
         case (state_q)
            S_RUN: begin
               if (pause) begin
                  state_d = S_PAUSED;
               end else if (div_wrap) begin
                  d_d = '0;
                  c_d = c_step;
                  if (c_step == term) begin
                     state_d = S_DONE;
                     exp_d   = 1'b1;
                  end
               end else begin
                  d_d = d_q + DW'(1);
               end
            end
            S_PAUSED: if (!pause) state_d = S_RUN;
            default: ;
         endcase
      end
   end

   // tick marks the edge that actually steps the count, so any input that
   // overrides the step this cycle suppresses it.
   assign tick     = (state_q == S_RUN) && div_wrap && !load && !start && !pause;
   assign running  = (state_q == S_RUN);
   assign time_out = (state_q == S_DONE);
   assign expired  = exp_q;
   assign bcd      = c_q;

   for (genvar g = 0; g < DIGITS; g++) begin : g_seg
      seg7_decoder u_seg (
         .digit (c_q[4*g +: 4]),
         .seg   (hex[7*g +: 7])
      );
   end
endmodule

// File: tb/tb_bcd_timer.sv
// tb/tb_bcd_timer.sv - self-checking bench for bcd_timer with behavioural model
module tb_bcd_timer;
   localparam int CLK_HZ = 10;
   localparam int TICK_HZ = 1;
   localparam int DIGITS = 2;
   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;
   localparam logic [6:0] SEG_TBL [10] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66,
                                           7'h6d, 7'h7d, 7'h07, 7'h7f, 7'h6f};

   logic        clk = 1'b0;
   logic        reset, start, pause, load, up_mode;
   logic [7:0]  load_bcd;
   logic [7:0]  bcd;
   logic [13:0] hex;
   logic        running, time_out, expired, tick;

   int total = 0;
   int bad = 0;

   bcd_timer #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DIGITS(DIGITS), .START_BCD(8'h60)) dut (
      .clk(clk), .reset(reset), .start(start), .pause(pause), .load(load),
      .load_bcd(load_bcd), .up_mode(up_mode), .bcd(bcd), .hex(hex),
      .running(running), .time_out(time_out), .expired(expired), .tick(tick)
   );

   always #5 clk = ~clk;

   // Reference model: count kept as a plain integer, direction as +1/-1.
   typedef struct {
      int p;
      int c;
      bit up;
      int d;
      int st;
      bit exp;
   } mdl_t;

   mdl_t mdl;

   function automatic int clamp_val(input logic [7:0] b);
      int v;
      int n;
      v = 0;
      for (int i = 0; i < DIGITS; i++) begin
         n = int'(b[4*i +: 4]);
         if (n > 9) n = 9;
         v += n * (10 ** i);
      end
      return v;
   endfunction

   function automatic logic [7:0] to_bcd(input int v);
      logic [7:0] r;
      for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
      return r;
   endfunction

   function automatic mdl_t mdl_reset();
      mdl_t s;
      s.p = 60; s.c = 60; s.up = 1'b0; s.d = 0; s.st = M_IDLE; s.exp = 1'b0;
      return s;
   endfunction

   function automatic mdl_t step(input mdl_t s, input bit ld, input bit st, input bit ps,
                                 input bit up, input logic [7:0] lb);
      mdl_t n;
      n = s;
      n.exp = 1'b0;
      if (ld) begin
         n.p = clamp_val(lb); n.c = n.p; n.d = 0; n.st = M_IDLE;
      end else if (st) begin
         n.up = up; n.c = up ? 0 : s.p; n.d = 0;
         if (s.p == 0) begin n.st = M_DONE; n.exp = 1'b1; end
         else n.st = M_RUN;
      end else if (s.st == M_RUN) begin
         if (ps) n.st = M_PAUSED;
         else if (s.d == DIV - 1) begin
            n.d = 0;
            n.c = s.c + (s.up ? 1 : -1);
            if (n.c == (s.up ? s.p : 0)) begin n.st = M_DONE; n.exp = 1'b1; end
         end else n.d = s.d + 1;
      end else if (s.st == M_PAUSED && !ps) begin
         n.st = M_RUN;
      end
      return n;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) mdl <= mdl_reset();
      else        mdl <= step(mdl, load, start, pause, up_mode, load_bcd);
   end

   function automatic logic [11:0] exp_vec();
      logic t;
      t = (mdl.st == M_RUN) && (mdl.d == DIV - 1) && !load && !start && !pause;
      return {to_bcd(mdl.c), mdl.st == M_RUN, mdl.st == M_DONE, mdl.exp, t};
   endfunction

   function automatic logic [13:0] exp_hex();
      logic [7:0] b;
      b = to_bcd(mdl.c);
      return {SEG_TBL[b[7:4]], SEG_TBL[b[3:0]]};
   endfunction

   task automatic drive(input bit l, input bit s, input bit p, input bit u, input logic [7:0] lb);
      @(negedge clk);
      load = l; start = s; pause = p; up_mode = u; load_bcd = lb;
      #1;
   endtask

   task automatic test_reset();
      #3;
      total++;
      if ({bcd, running, time_out, expired, tick} !== {8'h60, 4'b0000}) begin
         bad++;
         $display("FAIL reset_state got=%h exp=%h", {bcd, running, time_out, expired, tick}, {8'h60, 4'b0000});
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_down_default();
      int first_tick = -1, last_tick = -1, ticks = 0, exp_n = -1, exp_cnt = 0;
      bit gap_bad = 0;
      drive(0, 1, 0, 0, 8'h00);
      for (int n = 1; n <= 700; n++) begin
         drive(0, 0, 0, 0, 8'h00);
         total++;
         if ({bcd, running, time_out, expired, tick} !== exp_vec()) begin
            bad++;
            $display("FAIL down_seq n=%0d got=%h exp=%h", n, {bcd, running, time_out, expired, tick}, exp_vec());
         end
         total++;
         if (hex !== exp_hex()) begin
            bad++;
            $display("FAIL down_hex n=%0d got=%h exp=%h", n, hex, exp_hex());
         end
         if (tick) begin
            if (first_tick < 0) first_tick = n;
            else if (n - last_tick != DIV) gap_bad = 1;
            last_tick = n;
            ticks++;
         end
         if (expired) begin
            exp_cnt++;
            if (exp_n < 0) exp_n = n;
         end
      end
      total++;
      if (first_tick != 10) begin bad++; $display("FAIL down_first_tick got=%0d exp=10", first_tick); end
      total++;
      if (ticks != 60 || gap_bad) begin bad++; $display("FAIL down_ticks got=%0d gap_bad=%0d exp=60 gap_bad=0", ticks, gap_bad); end
      // expired rises on the 600th edge after the start edge
      total++;
      if (exp_n != 601) begin bad++; $display("FAIL down_expired_at got=%0d exp=601", exp_n); end
      total++;
      if (exp_cnt != 1) begin bad++; $display("FAIL down_expired_width got=%0d exp=1", exp_cnt); end
      total++;
      if ({bcd, time_out} !== {8'h00, 1'b1}) begin bad++; $display("FAIL down_hold got=%h exp=%h", {bcd, time_out}, {8'h00, 1'b1}); end
   endtask

   task automatic test_up_load12();
      logic [7:0] seq[$];
      logic [7:0] prev;
      bit carry_ok = 0;
      drive(1, 0, 0, 0, 8'h12);
      drive(0, 1, 0, 1, 8'h00);
      prev = 8'hff;
      for (int n = 1; n <= 150; n++) begin
         drive(0, 0, 0, 0, 8'h00);
         total++;
         if ({bcd, running, time_out, expired, tick} !== exp_vec()) begin
            bad++;
            $display("FAIL up_seq n=%0d got=%h exp=%h", n, {bcd, running, time_out, expired, tick}, exp_vec());
         end
         if (bcd !== prev) begin
            if (prev == 8'h09 && bcd == 8'h10) carry_ok = 1;
            seq.push_back(bcd);
            prev = bcd;
         end
      end
      total++;
      if (seq.size() != 13 || seq[0] !== 8'h00 || seq[12] !== 8'h12) begin
         bad++;
         $display("FAIL up_values got=%0d values exp=13 (00..12)", seq.size());
      end
      total++;
      if (!carry_ok) begin bad++; $display("FAIL up_carry got=0 exp=1"); end
      total++;
      if ({time_out, running} !== 2'b10) begin bad++; $display("FAIL up_done got=%b exp=10", {time_out, running}); end
   endtask

   task automatic test_pause();
      int waited = 0;
      int after = 0;
      logic [7:0] frozen;
      bit froze_ok = 1;
      drive(0, 1, 0, 0, 8'h00);
      do begin
         drive(0, 0, 0, 0, 8'h00);
         waited++;
      end while (!tick && waited < 30);
      total++;
      if (!tick) begin bad++; $display("FAIL pause_wait_tick got=0 exp=1"); return; end
      for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 8'h00);
      drive(0, 0, 1, 0, 8'h00);
      frozen = bcd;
      for (int i = 1; i < 37; i++) begin
         drive(0, 0, 1, 0, 8'h00);
         if (bcd !== frozen || tick) froze_ok = 0;
         total++;
         if ({bcd, running, time_out, expired, tick} !== exp_vec()) begin
            bad++;
            $display("FAIL pause_model i=%0d got=%h exp=%h", i, {bcd, running, time_out, expired, tick}, exp_vec());
         end
      end
      total++;
      if (!froze_ok) begin bad++; $display("FAIL pause_frozen got=changed exp=%h", frozen); end
      drive(0, 0, 0, 0, 8'h00);
      do begin
         drive(0, 0, 0, 0, 8'h00);
         after++;
      end while (!tick && after < 20);
      total++;
      if (after != 6) begin bad++; $display("FAIL pause_resume_tick got=%0d exp=6", after); end
   endtask

   task automatic test_load_clamp();
      drive(1, 1, 0, 0, 8'ha5);
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 0, 0, 8'h00);
         total++;
         if ({bcd, running, time_out} !== {8'h95, 2'b00}) begin
            bad++;
            $display("FAIL clamp_idle i=%0d got=%h exp=%h", i, {bcd, running, time_out}, {8'h95, 2'b00});
         end
      end
      drive(0, 1, 0, 0, 8'h00);
      drive(0, 0, 0, 0, 8'h00);
      total++;
      if ({bcd, running} !== {8'h95, 1'b1}) begin
         bad++;
         $display("FAIL clamp_run got=%h exp=%h", {bcd, running}, {8'h95, 1'b1});
      end
   endtask

   task automatic test_zero();
      drive(1, 0, 0, 0, 8'h00);
      drive(0, 1, 0, 0, 8'h00);
      total++;
      if (tick !== 1'b0) begin bad++; $display("FAIL zero_tick_at_start got=%b exp=0", tick); end
      drive(0, 0, 0, 0, 8'h00);
      total++;
      if ({time_out, expired, running, tick} !== 4'b1100) begin
         bad++;
         $display("FAIL zero_done got=%b exp=1100", {time_out, expired, running, tick});
      end
      drive(0, 0, 0, 0, 8'h00);
      total++;
      if ({time_out, expired, tick} !== 3'b100) begin
         bad++;
         $display("FAIL zero_after got=%b exp=100", {time_out, expired, tick});
      end
      drive(1, 0, 0, 0, 8'h05);
      drive(0, 0, 0, 0, 8'h00);
      total++;
      if ({time_out, expired} !== 2'b00) begin bad++; $display("FAIL load_in_done got=%b exp=00", {time_out, expired}); end
   endtask

   task automatic test_async_reset();
      drive(0, 1, 0, 0, 8'h00);
      for (int i = 0; i < 25; i++) drive(0, 0, 0, 0, 8'h00);
      @(posedge clk);
      #3 reset = 1'b0;
      #1;
      total++;
      if ({bcd, running, time_out, expired, tick} !== {8'h60, 4'b0000}) begin
         bad++;
         $display("FAIL async_reset got=%h exp=%h", {bcd, running, time_out, expired, tick}, {8'h60, 4'b0000});
      end
      @(negedge clk);
      reset = 1'b1;
      drive(0, 1, 0, 0, 8'h00);
      for (int n = 1; n <= 15; n++) begin
         drive(0, 0, 0, 0, 8'h00);
         total++;
         if ({bcd, running, time_out, expired, tick} !== exp_vec()) begin
            bad++;
            $display("FAIL post_reset n=%0d got=%h exp=%h", n, {bcd, running, time_out, expired, tick}, exp_vec());
         end
      end
      total++;
      if ({bcd, running} !== {8'h59, 1'b1}) begin
         bad++;
         $display("FAIL post_reset_count got=%h exp=%h", {bcd, running}, {8'h59, 1'b1});
      end
   endtask

   task automatic test_random();
      bit l, s, p, u;
      logic [7:0] lb;
      p = 0;
      for (int n = 0; n < 3000; n++) begin
         l = ($urandom_range(0, 59) == 0);
         s = ($urandom_range(0, 44) == 0);
         if ($urandom_range(0, 14) == 0) p = ~p;
         u = $urandom_range(0, 1);
         lb = $urandom_range(0, 1) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
         drive(l, s, p, u, lb);
         total++;
         if ({bcd, running, time_out, expired, tick} !== exp_vec()) begin
            bad++;
            $display("FAIL random n=%0d got=%h exp=%h", n, {bcd, running, time_out, expired, tick}, exp_vec());
         end
         total++;
         if (hex !== exp_hex()) begin
            bad++;
            $display("FAIL random_hex n=%0d got=%h exp=%h", n, hex, exp_hex());
         end
      end
   endtask

   initial begin
      reset = 1'b1; start = 0; pause = 0; load = 0; up_mode = 0; load_bcd = 8'h00;
      #2 reset = 1'b0;
      test_reset();
      test_down_default();
      test_up_load12();
      test_pause();
      test_load_clamp();
      test_zero();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
